plru_repl_ctrl: RTL and testbench

//  Replacement controller for a 4-way set-associative cache using tree pseudo-LRU.
//  - Holds one 3-bit PLRU tree per set.
//  - Updates the tree on every hit or fill.
//  - Answers victim queries with a registered way number.
//  - Runs a multi-cycle flush sweep that resets every tree.

---
 rtl/plru_repl_ctrl.sv | 118 +++++++++++
 tb/tb_plru_repl_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_repl_ctrl.sv
// Tree pseudo-LRU replacement controller for a 4-way set-associative cache.
// It keeps one 3-bit PLRU tree per set and updates that tree on every accepted
// hit or fill. Victim queries are answered with a registered way number one
// cycle later. A flush walks through all sets, one per cycle, and clears each
// tree.
module plru_repl_ctrl #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  output logic             busy,
  input  logic             flush,
  input  logic             acc_valid,
  input  logic [IDX_W-1:0] acc_idx,
  input  logic [1:0]       acc_way,
  input  logic             vic_req,
  input  logic [IDX_W-1:0] vic_idx,
  output logic             vic_valid,
  output logic [1:0]       vic_way
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             vic_valid_q, vic_valid_d;
  logic [1:0]       vic_way_q, vic_way_d;
  logic [2:0]       tree_q [NUM_SETS];
  logic [2:0]       tree_d [NUM_SETS];

  logic [2:0]       acc_tree;
  logic [2:0]       vic_tree;

  // Marks the touched way as most recently used. The bit on the other
  // subtree is left unchanged.
  function automatic logic [2:0] tree_update(input logic [2:0] t, input logic [1:0] way);
    logic [2:0] r;
    r = t;
    r[2] = ~way[1];
    if (way[1]) r[0] = ~way[0];
    else        r[1] = ~way[0];
    return r;
  endfunction

  // Follows the root bit to the LRU pair, then the leaf bit to the LRU way.
  function automatic logic [1:0] tree_lookup(input logic [2:0] t);
    return t[2] ? {1'b1, t[0]} : {1'b0, t[1]};
  endfunction

  assign busy      = (state_q == ST_FLUSH);
  assign ready     = ~busy;
  assign vic_valid = vic_valid_q;
  assign vic_way   = vic_way_q;

  // Next-state logic: apply accesses, answer queries with same-set forwarding,
  // and step the flush sweep.
  always_comb begin
    // NOTE: every signal assigned here first gets a default value, so this
    // block cannot infer a latch on any path through the case statement.
    state_d     = state_q;
    cnt_d       = cnt_q;
    vic_valid_d = 1'b0;
    vic_way_d   = vic_way_q;
    for (int i = 0; i < NUM_SETS; i++) tree_d[i] = tree_q[i];

    acc_tree = tree_update(tree_q[acc_idx], acc_way);
    vic_tree = (acc_valid && (acc_idx == vic_idx)) ? acc_tree : tree_q[vic_idx];

    case (state_q)
      ST_IDLE: begin
        if (acc_valid) tree_d[acc_idx] = acc_tree;
        if (vic_req) begin
          vic_valid_d = 1'b1;
          vic_way_d   = tree_lookup(vic_tree);
        end
        if (flush) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        tree_d[cnt_q] = 3'b000;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. A synchronous reset also aborts any flush in progress.
  always_ff @(posedge clk) begin
    // NOTE: the tree array is reset explicitly because reset must clear every
    // tree. That is why it is built from flops and not from a RAM macro.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vic_valid_q <= 1'b0;
      vic_way_q   <= 2'b00;
      for (int i = 0; i < NUM_SETS; i++) tree_q[i] <= 3'b000;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment. All
      // flops then update together from the values computed before the edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vic_valid_q <= vic_valid_d;
      vic_way_q   <= vic_way_d;
      for (int i = 0; i < NUM_SETS; i++) tree_q[i] <= tree_d[i];
    end
  end

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Self-checking bench for plru_repl_ctrl. The reference model describes each
// set in recency terms: the most recently used pair, and the most recently
// used way inside each pair. The victim is the older way of the older pair.
module tb_plru_repl_ctrl;

  localparam int NUM_SETS = 16;
  localparam int IDX_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready, busy, flush;
  logic             acc_valid;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_way;
  logic             vic_req;
  logic [IDX_W-1:0] vic_idx;
  logic             vic_valid;
  logic [1:0]       vic_way;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int mru_pair [NUM_SETS];
  int mru_in   [NUM_SETS][2];

  plru_repl_ctrl #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .busy      (busy),
    .flush     (flush),
    .acc_valid (acc_valid),
    .acc_idx   (acc_idx),
    .acc_way   (acc_way),
    .vic_req   (vic_req),
    .vic_idx   (vic_idx),
    .vic_valid (vic_valid),
    .vic_way   (vic_way)
  );

  always #5 clk = ~clk;

  // After a clear, the left pair is the older pair, way0 is older than way1,
  // and way2 is older than way3.
  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      mru_pair[s]  = 1;
      mru_in[s][0] = 1;
      mru_in[s][1] = 1;
    end
  endtask

  task automatic model_access(input int s, input int w);
    mru_pair[s]         = w / 2;
    mru_in[s][w / 2]    = w % 2;
  endtask

  function automatic logic [1:0] model_victim(input int s);
    int p;
    p = 1 - mru_pair[s];
    return 2'(2 * p + (1 - mru_in[s][p]));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; acc_valid = 0; acc_idx = '0; acc_way = '0; vic_req = 0; vic_idx = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    model_reset();
  endtask

  task automatic access(input int s, input int w);
    acc_valid = 1; acc_idx = IDX_W'(s); acc_way = 2'(w);
    cycle();
    acc_valid = 0;
  endtask

  task automatic query_check(input int s, input logic [1:0] exp, input string name);
    vic_req = 1; vic_idx = IDX_W'(s);
    cycle();
    vic_req = 0;
    checks++;
    if (vic_valid !== 1'b1 || vic_way !== exp) begin
      failures++;
      $display("FAIL %s: vic_valid=%b vic_way=%0d, expected vic_valid=1 vic_way=%0d",
               name, vic_valid, vic_way, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1 || vic_valid !== 1'b0 || vic_way !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b ready=%b vic_valid=%b vic_way=%0d, expected 0 1 0 0",
               busy, ready, vic_valid, vic_way);
    end
    query_check(3, 2'd0, "reset_query_set3");
    cycle();
    checks++;
    if (vic_valid !== 1'b0 || vic_way !== 2'd0) begin
      failures++;
      $display("FAIL vic_valid_pulse: vic_valid=%b vic_way=%0d, expected 0 0", vic_valid, vic_way);
    end
  endtask

  task automatic test_update_order();
    for (int w = 0; w < 4; w++) access(5, w);
    query_check(5, 2'd0, "order_0123");
    access(5, 0);
    query_check(5, 2'd2, "after_way0");
  endtask

  task automatic test_forwarding();
    acc_valid = 1; acc_idx = 7; acc_way = 0;
    vic_req = 1; vic_idx = 7;
    cycle();
    idle_inputs();
    checks++;
    if (vic_valid !== 1'b1 || vic_way !== 2'd2) begin
      failures++;
      $display("FAIL forward_same_set: vic_valid=%b vic_way=%0d, expected 1 2", vic_valid, vic_way);
    end
    acc_valid = 1; acc_idx = 9; acc_way = 0;
    vic_req = 1; vic_idx = 8;
    cycle();
    idle_inputs();
    checks++;
    if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
      failures++;
      $display("FAIL forward_other_set: vic_valid=%b vic_way=%0d, expected 1 0", vic_valid, vic_way);
    end
    query_check(9, 2'd2, "other_set_applied");
  endtask

  task automatic test_flush();
    int busy_cycles;
    int guard;
    for (int s = 0; s < NUM_SETS; s++) access(s, 0);
    flush = 1;
    cycle();
    flush = 0;
    // Hold a query and an access for the whole sweep. The access must be lost.
    vic_req = 1; vic_idx = 5;
    acc_valid = 1; acc_idx = 6; acc_way = 0;
    busy_cycles = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      busy_cycles++;
      checks++;
      if (ready !== 1'b0 || vic_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_gating: ready=%b vic_valid=%b, expected 0 0", ready, vic_valid);
      end
      cycle();
      guard++;
    end
    acc_valid = 0;
    checks++;
    if (busy_cycles != NUM_SETS || ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_length: busy_cycles=%0d ready=%b, expected %0d 1", busy_cycles, ready, NUM_SETS);
    end
    cycle();
    vic_req = 0;
    checks++;
    if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
      failures++;
      $display("FAIL held_query: vic_valid=%b vic_way=%0d, expected 1 0", vic_valid, vic_way);
    end
    query_check(6, 2'd0, "acc_during_flush_lost");
    query_check(12, 2'd0, "flushed_set12");
    model_reset();
  endtask

  task automatic test_reset_mid_flush();
    for (int s = 0; s < NUM_SETS; s++) access(s, 0);
    flush = 1;
    cycle();
    flush = 0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    model_reset();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1 || vic_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: busy=%b ready=%b vic_valid=%b, expected 0 1 0", busy, ready, vic_valid);
    end
    // Query every set back to back. Each query must produce one valid pulse.
    for (int s = 0; s < NUM_SETS; s++) begin
      vic_req = 1; vic_idx = IDX_W'(s);
      cycle();
      checks++;
      if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
        failures++;
        $display("FAIL reset_abort_set%0d: vic_valid=%b vic_way=%0d, expected 1 0", s, vic_valid, vic_way);
      end
    end
    vic_req = 0;
  endtask

  task automatic test_random();
    int         busy_left;
    logic       exp_vv;
    logic [1:0] exp_way;
    logic [1:0] last_way;
    do_reset();
    busy_left = 0;
    last_way  = 2'd0;
    for (int n = 0; n < 10000; n++) begin
      acc_valid = 1'($urandom_range(0, 1));
      acc_idx   = IDX_W'($urandom_range(0, NUM_SETS - 1));
      acc_way   = 2'($urandom_range(0, 3));
      vic_req   = 1'($urandom_range(0, 1));
      vic_idx   = ($urandom_range(0, 3) == 0) ? acc_idx : IDX_W'($urandom_range(0, NUM_SETS - 1));
      flush     = ($urandom_range(0, 399) == 0);
      exp_vv    = 1'b0;
      exp_way   = last_way;
      if (busy_left == 0) begin
        if (acc_valid) model_access(int'(acc_idx), int'(acc_way));
        if (vic_req) begin
          exp_vv  = 1'b1;
          exp_way = model_victim(int'(vic_idx));
        end
        if (flush) begin
          busy_left = NUM_SETS;
          model_reset();
        end
      end else begin
        busy_left--;
      end
      cycle();
      last_way = exp_way;
      checks++;
      if (vic_valid !== exp_vv || vic_way !== exp_way || busy !== (busy_left > 0)) begin
        failures++;
        $display("FAIL random_cycle%0d: vic_valid=%b vic_way=%0d busy=%b, expected %b %0d %b",
                 n, vic_valid, vic_way, busy, exp_vv, exp_way, busy_left > 0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_update_order();
    test_forwarding();
    test_flush();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
